traffic_sensor_cond: RTL and testbench

TRAFFIC_SENSOR_COND -- requirements
Module: traffic_sensor_cond

---
 rtl/traffic_sensor_cond.sv | 61 ++++++
 tb/tb_traffic_sensor_cond.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: synchronizes and debounces two car sensors and two parade buttons, turns button presses into one-cycle pulses and emits a periodic tick
module traffic_sensor_cond #(
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV = 10
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_sensA_raw,
  input  logic i_sensB_raw,
  input  logic i_parade_btn,
  input  logic i_reset_btn,
  output logic o_TA,
  output logic o_TB,
  output logic o_P,
  output logic o_R,
  output logic o_tick
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] C_MAX = CW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_PRE = TW'(TICK_DIV - 2);
  logic [3:0] raw, s1, s2, d;
  logic [1:0] pd;
  logic [CW-1:0] c [4];
  logic [TW-1:0] t;
  logic rise_p, rise_r;
  assign raw = {i_reset_btn, i_parade_btn, i_sensB_raw, i_sensA_raw};
  assign rise_p = d[2] & ~pd[0];
  assign rise_r = d[3] & ~pd[1];
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      s1 <= '0;
      s2 <= '0;
      d <= '0;
      pd <= '0;
      t <= '0;
      for (int i = 0; i < 4; i++) c[i] <= '0;
      o_TA <= 1'b0;
      o_TB <= 1'b0;
      o_P <= 1'b0;
      o_R <= 1'b0;
      o_tick <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++)
        if (s2[i] == d[i]) c[i] <= '0;
        else if (c[i] == C_MAX) begin
          d[i] <= s2[i];
          c[i] <= '0;
        end else c[i] <= c[i] + CW'(1);
      pd <= d[3:2];
      o_TA <= d[0];
      o_TB <= d[1];
      o_R <= rise_r;
      o_P <= rise_p & ~rise_r;
      t <= (t == T_MAX) ? '0 : t + TW'(1);
      o_tick <= (t == T_PRE);
    end
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond: directed and randomized checks of traffic_sensor_cond against a sample-window reference model
module tb_traffic_sensor_cond;
  localparam int DB = 4;
  localparam int TD = 10;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sa = 1'b0;
  logic sb = 1'b0;
  logic pb = 1'b0;
  logic rb = 1'b0;
  logic ta, tb_o, p, r, tick;
  int checks = 0;
  int fails = 0;
  bit h0 [4];
  bit h1 [4];
  bit d [4];
  bit dp [4];
  bit win [4][$];
  int n;
  bit e_ta, e_tb, e_p, e_r, e_tick;
  always #5 clk = ~clk;
  traffic_sensor_cond #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_sensA_raw(sa),
    .i_sensB_raw(sb),
    .i_parade_btn(pb),
    .i_reset_btn(rb),
    .o_TA(ta),
    .o_TB(tb_o),
    .o_P(p),
    .o_R(r),
    .o_tick(tick)
  );
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      h0[i] = 0;
      h1[i] = 0;
      d[i] = 0;
      dp[i] = 0;
      win[i].delete();
    end
    n = 0;
    {e_ta, e_tb, e_p, e_r, e_tick} = '0;
  endfunction
  function automatic void model_edge();
    bit cur [4];
    bit used, all_diff;
    cur[0] = sa;
    cur[1] = sb;
    cur[2] = pb;
    cur[3] = rb;
    e_ta = d[0];
    e_tb = d[1];
    e_r = d[3] && !dp[3];
    e_p = d[2] && !dp[2] && !e_r;
    dp = d;
    for (int i = 0; i < 4; i++) begin
      used = h1[i];
      h1[i] = h0[i];
      h0[i] = cur[i];
      win[i].push_back(used);
      if (win[i].size() > DB) void'(win[i].pop_front());
      all_diff = (win[i].size() == DB);
      foreach (win[i][j]) if (win[i][j] == d[i]) all_diff = 0;
      if (all_diff) begin
        d[i] = used;
        win[i].delete();
      end
    end
    n++;
    e_tick = (n % TD) == TD - 1;
  endfunction
  task automatic chk(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
    end
  endtask
  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".TA"}, ta, e_ta);
    chk({tag, ".TB"}, tb_o, e_tb);
    chk({tag, ".P"}, p, e_p);
    chk({tag, ".R"}, r, e_r);
    chk({tag, ".tick"}, tick, e_tick);
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    if (rstn) model_edge();
    #1;
    chk_all(tag);
  endtask
  task automatic wait_ta(input logic v, output int k);
    k = 0;
    do begin
      step("wait_ta");
      k++;
    end while (ta !== v && k < 20);
  endtask
  initial begin
    int k, pc, rc, first, last, ticks, first_ta;
    bit seen;
    model_reset();
    #2;
    chk_all("reset_hold");
    repeat (3) step("in_reset");
    rstn = 1'b1;
    first = 0;
    last = 0;
    ticks = 0;
    for (int j = 1; j <= 100; j++) begin
      step("idle");
      if (tick) begin
        ticks++;
        if (first == 0) first = j + 1;
        else chk_int("tick_spacing", j - last, TD);
        last = j;
      end
    end
    chk_int("first_tick_cycle", first, TD);
    chk_int("tick_count_100", ticks, 10);
    sa = 1'b1;
    wait_ta(1'b1, k);
    chk_int("ta_rise_latency", k, 7);
    repeat (10) step("ta_hold");
    chk("ta_stays_high", ta, 1'b1);
    sa = 1'b0;
    wait_ta(1'b0, k);
    chk_int("ta_fall_latency", k, 7);
    sb = 1'b1;
    repeat (3) step("glitch3");
    sb = 1'b0;
    seen = 0;
    repeat (10) begin
      step("glitch3_after");
      if (tb_o) seen = 1;
    end
    chk("glitch3_tb_low", seen, 1'b0);
    sb = 1'b1;
    repeat (4) step("glitch4");
    sb = 1'b0;
    repeat (3) step("glitch4_after");
    chk("glitch4_accept", tb_o, 1'b1);
    repeat (12) step("tb_fall");
    chk("tb_back_low", tb_o, 1'b0);
    pb = 1'b1;
    pc = 0;
    rc = 0;
    repeat (50) begin
      step("parade_hold");
      pc += int'(p);
      rc += int'(r);
    end
    pb = 1'b0;
    repeat (10) begin
      step("parade_release");
      pc += int'(p);
      rc += int'(r);
    end
    chk_int("parade_p_pulses", pc, 1);
    chk_int("parade_r_pulses", rc, 0);
    pb = 1'b1;
    rb = 1'b1;
    pc = 0;
    rc = 0;
    repeat (20) begin
      step("both_hold");
      pc += int'(p);
      rc += int'(r);
    end
    pb = 1'b0;
    rb = 1'b0;
    repeat (10) begin
      step("both_release");
      pc += int'(p);
      rc += int'(r);
    end
    chk_int("both_p_pulses", pc, 0);
    chk_int("both_r_pulses", rc, 1);
    sa = 1'b1;
    wait_ta(1'b1, k);
    chk_int("ta_rise_latency2", k, 7);
    sb = 1'b1;
    repeat (4) step("mid_debounce");
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    repeat (2) step("reset_again");
    rstn = 1'b1;
    first = 0;
    first_ta = 0;
    for (int j = 1; j <= 12; j++) begin
      step("post_reset");
      if (tick && first == 0) first = j + 1;
      if (ta && first_ta == 0) first_ta = j;
    end
    chk_int("first_tick_after_reset", first, TD);
    chk_int("held_input_after_reset", first_ta, 7);
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 3) == 0) sa = ~sa;
      if ($urandom_range(0, 3) == 0) sb = ~sb;
      if ($urandom_range(0, 5) == 0) pb = ~pb;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      step("random");
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
